time_step_scheduler: RTL and testbench

Sequencing controller for the emulator's global time base. It snapshots next-event time requests from N requesters and scans them one per cycle to find the earliest. It then commits that time as the new global time and strobes a grant to every requester whose event fires at that time. It replaces the purely combinational two-input minimum select, allows N>2 without wide comparator trees, and adds causality and overflow checking.

---
 rtl/time_step_scheduler_if.sv | 58 +++++
 rtl/time_step_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_time_step_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_step_scheduler_if.sv
// time_step_scheduler_if
//
// Bundles the time-step request/response signals exchanged between the
// global time-base scheduler and its environment.
//
// Signals:
//   en            step request (environment -> scheduler)
//   req_valid     per-requester pending-event flags (environment -> scheduler)
//   req_time      packed per-requester event times, requester i in
//                 [i*TIME_WIDTH +: TIME_WIDTH] (environment -> scheduler)
//   time_curr     committed global time (scheduler -> environment)
//   time_valid    one-cycle strobe marking a commit (scheduler -> environment)
//   grant         one-cycle mask of requesters firing at time_curr
//   busy          scheduler is scanning or committing
//   causality_err sticky: a valid request time lay in the past
//   overflow      sticky: a free-running advance saturated
//
// Modports:
//   master  environment side (drives requests, observes results)
//   slave   scheduler side
interface time_step_scheduler_if #(
    parameter int N          = 4,
    parameter int TIME_WIDTH = 32
);
    logic                    en;
    logic [N-1:0]            req_valid;
    logic [N*TIME_WIDTH-1:0] req_time;
    logic [TIME_WIDTH-1:0]   time_curr;
    logic                    time_valid;
    logic [N-1:0]            grant;
    logic                    busy;
    logic                    causality_err;
    logic                    overflow;

    modport master (
        output en,
        output req_valid,
        output req_time,
        input  time_curr,
        input  time_valid,
        input  grant,
        input  busy,
        input  causality_err,
        input  overflow
    );

    modport slave (
        input  en,
        input  req_valid,
        input  req_time,
        output time_curr,
        output time_valid,
        output grant,
        output busy,
        output causality_err,
        output overflow
    );
endinterface

// File: rtl/time_step_scheduler.sv
// time_step_scheduler
//
// Sequencing controller for the emulator's global time base. On a step
// request it snapshots all next-event requests, scans them one per cycle to
// find the earliest (clamped to the current time), then commits that time
// and strobes a grant to every requester whose event fires at it. With no
// valid request the time base advances by DT_MAX, saturating at all-ones.
//
// Parameters:
//   N           number of requesters (1..16)
//   TIME_WIDTH  width of unsigned time values
//   DT_MAX      advance applied when no request is valid
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   time_step_scheduler_if.slave (en, req_valid, req_time in;
//         time_curr, time_valid, grant, busy, causality_err, overflow out)
//
// Timing: en sampled in IDLE at cycle t -> N scan cycles -> COMMIT cycle
// t+N+1 with time_valid/grant asserted -> IDLE again at t+N+2.
module time_step_scheduler #(
    parameter int N          = 4,
    parameter int TIME_WIDTH = 32,
    parameter int DT_MAX     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    time_step_scheduler_if.slave  bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N - 1);
    localparam logic [TIME_WIDTH:0]   DT_EXT   = (TIME_WIDTH + 1)'(DT_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    // Control strobes decoded from the FSM state
    logic start_step;
    logic scan_step;
    logic last_scan;
    logic busy_o;

    // Snapshot of the requests taken when the step starts
    logic [N-1:0]          snap_valid_q;
    logic [TIME_WIDTH-1:0] snap_time_q [N];

    // Scan bookkeeping
    logic [IDX_W-1:0]      idx_q;
    logic                  have_min_q;
    logic [TIME_WIDTH-1:0] min_q;
    logic [N-1:0]          mask_q;

    // Registered outputs
    logic [TIME_WIDTH-1:0] time_curr_q;
    logic                  time_valid_q;
    logic [N-1:0]          grant_q;
    logic                  causality_q;
    logic                  overflow_q;

    // Scan datapath
    logic                  cur_valid;
    logic [TIME_WIDTH-1:0] cur_time;
    logic [N-1:0]          cur_onehot;
    logic [TIME_WIDTH-1:0] cand;
    logic                  late;
    logic                  have_min_nxt;
    logic [TIME_WIDTH-1:0] min_nxt;
    logic [N-1:0]          mask_nxt;

    // Commit datapath
    logic [TIME_WIDTH:0]   adv_sum;
    logic [TIME_WIDTH-1:0] commit_time;
    logic [N-1:0]          commit_grant;
    logic                  commit_ovf;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. en only matters in IDLE; a started step
    // always runs to completion.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.en) state_nxt = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        start_step = 1'b0;
        scan_step  = 1'b0;
        last_scan  = 1'b0;
        busy_o     = (state_q != IDLE);
        case (state_q)
            IDLE:    start_step = bus.en;
            SCAN: begin
                scan_step = 1'b1;
                last_scan = (idx_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Select the snapshot entry under scan. A decoded loop rather than a
    // direct array index keeps out-of-range indices harmless when N is
    // not a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        cur_valid  = 1'b0;
        cur_time   = '0;
        cur_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_valid     = snap_valid_q[i];
                cur_time      = snap_time_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Running minimum update. Requests in the past are clamped to the
    // current time so time never moves backwards; they still fire now.
    // ------------------------------------------------------------------
    always_comb begin
        late         = cur_valid && (cur_time < time_curr_q);
        cand         = (cur_time < time_curr_q) ? time_curr_q : cur_time;
        have_min_nxt = have_min_q;
        min_nxt      = min_q;
        mask_nxt     = mask_q;
        if (cur_valid) begin
            if (!have_min_q || (cand < min_q)) begin
                have_min_nxt = 1'b1;
                min_nxt      = cand;
                mask_nxt     = cur_onehot;
            end else if (cand == min_q) begin
                mask_nxt = mask_q | cur_onehot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit value. It is computed from the *next* running minimum so the
    // last scanned entry is folded in on the same edge that enters COMMIT,
    // which lets time_curr and time_valid update together.
    // ------------------------------------------------------------------
    always_comb begin
        adv_sum      = {1'b0, time_curr_q} + DT_EXT;
        commit_time  = adv_sum[TIME_WIDTH-1:0];
        commit_grant = '0;
        commit_ovf   = 1'b0;
        if (have_min_nxt) begin
            commit_time  = min_nxt;
            commit_grant = mask_nxt;
        end else if (adv_sum[TIME_WIDTH]) begin
            commit_time = '1;
            commit_ovf  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot and scan registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                snap_time_q[i] <= '0;
            end
            idx_q      <= '0;
            have_min_q <= 1'b0;
            min_q      <= '0;
            mask_q     <= '0;
        end else if (start_step) begin
            snap_valid_q <= bus.req_valid;
            for (int i = 0; i < N; i++) begin
                snap_time_q[i] <= bus.req_time[i*TIME_WIDTH +: TIME_WIDTH];
            end
            idx_q      <= '0;
            have_min_q <= 1'b0;
            min_q      <= '0;
            mask_q     <= '0;
        end else if (scan_step) begin
            idx_q      <= idx_q + IDX_W'(1);
            have_min_q <= have_min_nxt;
            min_q      <= min_nxt;
            mask_q     <= mask_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Time base, commit strobes and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_curr_q  <= '0;
            time_valid_q <= 1'b0;
            grant_q      <= '0;
            causality_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            time_valid_q <= last_scan;
            grant_q      <= last_scan ? commit_grant : '0;
            if (scan_step && late) begin
                causality_q <= 1'b1;
            end
            if (last_scan) begin
                time_curr_q <= commit_time;
                if (commit_ovf) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.time_curr     = time_curr_q;
    assign bus.time_valid    = time_valid_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_o;
    assign bus.causality_err = causality_q;
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_time_step_scheduler.sv
// tb_time_step_scheduler
//
// Directed bench for time_step_scheduler (N=4, TIME_WIDTH=32, DT_MAX=1024).
// A cycle-level reference model derived from the step rules tracks the
// expected outputs; a compare process checks them every cycle, and each
// directed step also checks hand-computed literal results.
module tb_time_step_scheduler;

    localparam int N  = 4;
    localparam int TW = 32;
    localparam int DT = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    time_step_scheduler_if #(.N(N), .TIME_WIDTH(TW)) bus ();

    time_step_scheduler #(
        .N          (N),
        .TIME_WIDTH (TW),
        .DT_MAX     (DT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int          m_phase;
    logic [31:0] m_tc;
    logic        m_tv;
    logic [3:0]  m_grant;
    logic        m_caus;
    logic        m_ovf;
    logic [3:0]  p_valid;
    logic [31:0] p_time [N];

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] v, input logic [31:0] t0,
                                  input logic [31:0] t1, input logic [31:0] t2,
                                  input logic [31:0] t3, input logic en_val);
        @(negedge clk);
        #1;
        bus.req_valid = v;
        bus.req_time  = {t3, t2, t1, t0};
        bus.en        = en_val;
    endtask

    // Reference model: a step takes the snapshot at the accepting edge, the
    // result lands N edges later and is shown for one cycle.
    always @(posedge clk or negedge rst) begin
        longint unsigned best;
        longint unsigned c;
        longint unsigned sum;
        logic            any;
        logic [3:0]      mask;
        if (!rst) begin
            m_phase <= 0;
            m_tc    <= '0;
            m_tv    <= 1'b0;
            m_grant <= '0;
            m_caus  <= 1'b0;
            m_ovf   <= 1'b0;
            p_valid <= '0;
            for (int i = 0; i < N; i++) p_time[i] <= '0;
        end else if (m_phase == 0) begin
            m_tv    <= 1'b0;
            m_grant <= '0;
            if (bus.en) begin
                m_phase <= 1;
                p_valid <= bus.req_valid;
                for (int i = 0; i < N; i++) p_time[i] <= bus.req_time[i*TW +: TW];
            end
        end else if (m_phase < N) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == N) begin
            any  = 1'b0;
            best = 0;
            mask = '0;
            for (int i = 0; i < N; i++) begin
                if (p_valid[i]) begin
                    c = (p_time[i] < m_tc) ? longint'(m_tc) : longint'(p_time[i]);
                    if (p_time[i] < m_tc) m_caus <= 1'b1;
                    if (!any || c < best) best = c;
                    any = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                c = (p_time[i] < m_tc) ? longint'(m_tc) : longint'(p_time[i]);
                if (p_valid[i] && c == best) mask[i] = 1'b1;
            end
            if (any) begin
                m_tc    <= best[31:0];
                m_grant <= mask;
            end else begin
                sum = longint'(m_tc) + longint'(DT);
                if (sum > 64'hFFFF_FFFF) begin
                    m_tc  <= 32'hFFFF_FFFF;
                    m_ovf <= 1'b1;
                end else begin
                    m_tc <= sum[31:0];
                end
                m_grant <= '0;
            end
            m_tv    <= 1'b1;
            m_phase <= N + 1;
        end else begin
            m_phase <= 0;
            m_tv    <= 1'b0;
            m_grant <= '0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst && chk_on) begin
            check_output("cyc_time_curr", bus.time_curr, m_tc);
            check_output("cyc_time_valid", {31'b0, bus.time_valid}, {31'b0, m_tv});
            check_output("cyc_grant", {28'b0, bus.grant}, {28'b0, m_grant});
            check_output("cyc_busy", {31'b0, bus.busy}, {31'b0, (m_phase != 0)});
            if (m_phase == 0 || m_phase == N + 1) begin
                check_output("cyc_causality", {31'b0, bus.causality_err}, {31'b0, m_caus});
                check_output("cyc_overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
            end
        end
    end

    // One complete step with literal expectations on latency and results
    task automatic run_step(input string name, input logic [3:0] v,
                            input logic [31:0] t0, input logic [31:0] t1,
                            input logic [31:0] t2, input logic [31:0] t3,
                            input logic [31:0] exp_tc, input logic [3:0] exp_g,
                            input logic exp_c, input logic exp_o, input bit scramble);
        int   lat;
        logic got;
        apply_stimulus(v, t0, t1, t2, t3, 1'b1);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            got = bus.time_valid;
            if (c == 1) begin
                #1 bus.en = 1'b0;
            end
            if (scramble && c == 2) begin
                #1;
                bus.req_valid = 4'b1111;
                bus.req_time  = {4{32'd1130}};
            end
            if (got) begin
                lat = c;
                break;
            end
        end
        check_output({name, "_latency"}, lat, N + 1);
        check_output({name, "_time_curr"}, bus.time_curr, exp_tc);
        check_output({name, "_grant"}, {28'b0, bus.grant}, {28'b0, exp_g});
        check_output({name, "_causality"}, {31'b0, bus.causality_err}, {31'b0, exp_c});
        check_output({name, "_overflow"}, {31'b0, bus.overflow}, {31'b0, exp_o});
        check_output({name, "_model_tc"}, m_tc, exp_tc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_time  = '0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        chk_on = 1'b1;

        // Idle after reset
        repeat (10) @(negedge clk);
        check_output("idle_time_curr", bus.time_curr, 32'd0);
        check_output("idle_time_valid", {31'b0, bus.time_valid}, 32'd0);
        check_output("idle_busy", {31'b0, bus.busy}, 32'd0);

        run_step("basic_min",  4'b1111, 32'd50, 32'd20, 32'd70, 32'd20,
                 32'd20, 4'b1010, 1'b0, 1'b0, 1'b0);
        run_step("to_100",     4'b0100, 32'd0, 32'd0, 32'd100, 32'd0,
                 32'd100, 4'b0100, 1'b0, 1'b0, 1'b0);
        run_step("no_valid",   4'b0000, 32'd0, 32'd0, 32'd0, 32'd0,
                 32'd1124, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_step("zero_step",  4'b1001, 32'd1124, 32'd9, 32'd9, 32'd1124,
                 32'd1124, 4'b1001, 1'b0, 1'b0, 1'b0);
        run_step("snapshot",   4'b0110, 32'd0, 32'd2000, 32'd3000, 32'd0,
                 32'd2000, 4'b0010, 1'b0, 1'b0, 1'b1);

        // Fresh time base for the causality and saturation runs
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        run_step("to_500",     4'b0001, 32'd500, 32'd0, 32'd0, 32'd0,
                 32'd500, 4'b0001, 1'b0, 1'b0, 1'b0);
        run_step("causality",  4'b0011, 32'd400, 32'd600, 32'd0, 32'd0,
                 32'd500, 4'b0001, 1'b1, 1'b0, 1'b0);
        run_step("clean_after", 4'b0010, 32'd0, 32'd700, 32'd0, 32'd0,
                 32'd700, 4'b0010, 1'b1, 1'b0, 1'b0);
        run_step("near_top",   4'b1000, 32'd0, 32'd0, 32'd0, 32'hFFFF_FF00,
                 32'hFFFF_FF00, 4'b1000, 1'b1, 1'b0, 1'b0);
        run_step("saturate",   4'b0000, 32'd0, 32'd0, 32'd0, 32'd0,
                 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_step("sat_hold",   4'b0000, 32'd0, 32'd0, 32'd0, 32'd0,
                 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 1'b0);

        // Reset two cycles into a scan
        apply_stimulus(4'b0001, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        #1 bus.en = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("midrst_time_curr", bus.time_curr, 32'd0);
        check_output("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check_output("midrst_time_valid", {31'b0, bus.time_valid}, 32'd0);
        check_output("midrst_grant", {28'b0, bus.grant}, 32'd0);
        check_output("midrst_causality", {31'b0, bus.causality_err}, 32'd0);
        check_output("midrst_overflow", {31'b0, bus.overflow}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.time_valid) pulses++;
        end
        check_output("midrst_no_pulse", pulses, 32'd0);
        check_output("midrst_after_tc", bus.time_curr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
